// File: rtl/proc_pkg.sv
// Shared processor ISA constants: opcode/ALU-op encodings, field positions
// and the interlock FSM state type.
package proc_pkg;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 22;
   localparam int RS_HI  = 21;
   localparam int RS_LO  = 17;
   localparam int RT_HI  = 16;
   localparam int RT_LO  = 12;
   localparam int ALU_HI = 6;
   localparam int ALU_LO = 2;

   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_BEQ  = 5'b01011;
   localparam logic [4:0] OP_LED  = 5'b01100;
   localparam logic [4:0] OP_CAP  = 5'b01101;

   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_MD_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/insn_reads_decode.sv
// Per-instruction decode of which register fields are read as sources,
// plus lw/sw/mult-div class flags.
module insn_reads_decode
   import proc_pkg::*;
(
   input  logic [31:0] insn,
   output logic        reads_rs,
   output logic        reads_rt,
   output logic        reads_rd,
   output logic        is_lw,
   output logic        is_sw,
   output logic        is_md
);

   logic [4:0] opc;
   logic [4:0] alu;
   logic       is_r;
   logic       is_shift;
   logic       unused_bits;

   assign opc      = insn[OPC_HI:OPC_LO];
   assign alu      = insn[ALU_HI:ALU_LO];
   assign is_r     = (opc == OP_R);
   // sll and sra share the 0010x encoding and take a shamt instead of rt
   assign is_shift = (alu[4:1] == ALU_SLL[4:1]);

   assign reads_rs = opc inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BNE,
                                 OP_BLT, OP_BEQ, OP_LED, OP_CAP};
   assign reads_rt = is_r && !is_shift;
   assign reads_rd = opc inside {OP_BNE, OP_BLT, OP_JR, OP_SW, OP_BEQ, OP_LED};
   assign is_lw    = (opc == OP_LW);
   assign is_sw    = (opc == OP_SW);
   assign is_md    = is_r && ((alu == ALU_MUL) || (alu == ALU_DIV));

   assign unused_bits = ^{insn[RD_HI:7], insn[1:0]};

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and mult/div interlock: PC/FD/DX holds, DX/XM bubbles, multdiv
// handshake. Optional stall counter enabled by defining HAZARD_PERF_EN.
module hazard_stall_unit
   import proc_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [31:0]      fd_insn,
   input  logic [31:0]      dx_insn,
   input  logic             branch_taken,
   input  logic             md_ready,
   output logic             pc_stall,
   output logic             fd_stall,
   output logic             dx_stall,
   output logic             dx_bubble,
   output logic             xm_bubble,
   output logic             md_start,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int unsigned TO_W      = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam int unsigned TO_LAST_I = (MD_TIMEOUT == 0) ? 0 : MD_TIMEOUT - 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];

   logic fd_rs_rd, fd_rt_rd, fd_rd_rd, fd_is_sw;
   logic dx_is_lw, dx_is_md;
   logic fd_is_lw, fd_is_md, dx_rs_rd, dx_rt_rd, dx_rd_rd, dx_is_sw;
   logic unused_dec;

   insn_reads_decode u_fd_dec (
      .insn     (fd_insn),
      .reads_rs (fd_rs_rd),
      .reads_rt (fd_rt_rd),
      .reads_rd (fd_rd_rd),
      .is_lw    (fd_is_lw),
      .is_sw    (fd_is_sw),
      .is_md    (fd_is_md)
   );

   insn_reads_decode u_dx_dec (
      .insn     (dx_insn),
      .reads_rs (dx_rs_rd),
      .reads_rt (dx_rt_rd),
      .reads_rd (dx_rd_rd),
      .is_lw    (dx_is_lw),
      .is_sw    (dx_is_sw),
      .is_md    (dx_is_md)
   );

   assign unused_dec = ^{fd_is_lw, fd_is_md, dx_rs_rd, dx_rt_rd, dx_rd_rd, dx_is_sw};

   logic [4:0] dx_rd;
   logic       hit_rs, hit_rt, hit_rd, lu_hit;

   assign dx_rd  = dx_insn[RD_HI:RD_LO];
   assign hit_rs = fd_rs_rd && (fd_insn[RS_HI:RS_LO] == dx_rd);
   assign hit_rt = fd_rt_rd && (fd_insn[RT_HI:RT_LO] == dx_rd);
   assign hit_rd = fd_rd_rd && (fd_insn[RD_HI:RD_LO] == dx_rd);
   // sw store data matching only through rd is covered by the WM bypass
   assign lu_hit = dx_is_lw && (dx_rd != 5'd0) && (hit_rs || hit_rt || hit_rd) &&
                   !(fd_is_sw && hit_rd && !hit_rs && !hit_rt);

   hz_state_e       state_q, state_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            pc_c, fd_c, dx_c, dxb_c, xmb_c, start_c, tout_c;

   always_comb begin
      state_d = state_q;
      to_d    = to_q;
      pc_c    = 1'b0;
      fd_c    = 1'b0;
      dx_c    = 1'b0;
      dxb_c   = 1'b0;
      xmb_c   = 1'b0;
      start_c = 1'b0;
      tout_c  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (dx_is_md) begin
               start_c = 1'b1;
               {pc_c, fd_c, dx_c, xmb_c} = 4'b1111;
               state_d = ST_MD_WAIT;
               to_d    = '0;
            end else if (lu_hit && !branch_taken) begin
               {pc_c, fd_c, dxb_c} = 3'b111;
            end
         end
         ST_MD_WAIT: begin
            if (md_ready) begin
               state_d = ST_RUN;
            end else if ((MD_TIMEOUT != 0) && (to_q == TO_LAST)) begin
               tout_c  = 1'b1;
               state_d = ST_RUN;
            end else begin
               {pc_c, fd_c, dx_c, xmb_c} = 4'b1111;
               to_d = to_q + TO_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
      end
   end

   // Outputs forced low during reset even though decode stays live
   assign pc_stall   = reset_n & pc_c;
   assign fd_stall   = reset_n & fd_c;
   assign dx_stall   = reset_n & dx_c;
   assign dx_bubble  = reset_n & dxb_c;
   assign xm_bubble  = reset_n & xmb_c;
   assign md_start   = reset_n & start_c;
   assign md_timeout = reset_n & tout_c;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else if (fd_stall && !(&cnt_q))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign stall_count = cnt_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use cases, mult/div handshake,
// timeout release, async reset and the optional stall counter.
module tb_hazard_stall_unit;

`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // output vector order: pc, fd, dx, dx_bubble, xm_bubble, md_start, md_timeout
   localparam logic [6:0] V_NONE  = 7'b0000000;
   localparam logic [6:0] V_LU    = 7'b1101000;
   localparam logic [6:0] V_START = 7'b1110110;
   localparam logic [6:0] V_WAIT  = 7'b1110100;
   localparam logic [6:0] V_TOUT  = 7'b0000001;

   localparam logic [4:0] E_LW  = 5'b01000;
   localparam logic [4:0] E_SW  = 5'b00111;
   localparam logic [4:0] E_BNE = 5'b00010;
   localparam logic [4:0] A_ADD = 5'b00000;
   localparam logic [4:0] A_SLL = 5'b00100;
   localparam logic [4:0] A_MUL = 5'b00110;
   localparam logic [4:0] A_DIV = 5'b00111;
   localparam logic [31:0] NOP  = 32'd0;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] fd_insn, dx_insn;
   logic        branch_taken, md_ready;

   logic        a_pc, a_fd, a_dx, a_dxb, a_xmb, a_st, a_to;
   logic        b_pc, b_fd, b_dx, b_dxb, b_xmb, b_st, b_to;
   logic [15:0] a_cnt;
   logic [3:0]  b_cnt;
   logic [6:0]  a_vec, b_vec;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   hazard_stall_unit u_dut (
      .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .dx_insn(dx_insn),
      .branch_taken(branch_taken), .md_ready(md_ready),
      .pc_stall(a_pc), .fd_stall(a_fd), .dx_stall(a_dx), .dx_bubble(a_dxb),
      .xm_bubble(a_xmb), .md_start(a_st), .md_timeout(a_to), .stall_count(a_cnt)
   );

   hazard_stall_unit #(.MD_TIMEOUT(8), .CNT_W(4)) u_to (
      .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .dx_insn(dx_insn),
      .branch_taken(branch_taken), .md_ready(md_ready),
      .pc_stall(b_pc), .fd_stall(b_fd), .dx_stall(b_dx), .dx_bubble(b_dxb),
      .xm_bubble(b_xmb), .md_start(b_st), .md_timeout(b_to), .stall_count(b_cnt)
   );

   assign a_vec = {a_pc, a_fd, a_dx, a_dxb, a_xmb, a_st, a_to};
   assign b_vec = {b_pc, b_fd, b_dx, b_dxb, b_xmb, b_st, b_to};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc_edge();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] r_ins(input logic [4:0] rd, rs, rt, alu);
      return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs);
      return {op, rd, rs, 17'd5};
   endfunction

   logic [31:0] lu_dx  [9];
   logic [31:0] lu_fd  [9];
   logic        lu_br  [9];
   logic [6:0]  lu_exp [9];
   int          n_stall, n_start;
   logic [6:0]  exp_v;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      lu_dx  = '{i_ins(E_LW,5,2), i_ins(E_LW,5,2), i_ins(E_LW,5,2), i_ins(E_LW,0,2),
                 i_ins(E_LW,5,2), i_ins(E_LW,5,2), i_ins(E_LW,5,2), r_ins(5,1,2,A_ADD),
                 i_ins(E_LW,5,2)};
      lu_fd  = '{r_ins(6,1,5,A_ADD), i_ins(E_SW,5,3), i_ins(E_SW,1,5), r_ins(6,0,0,A_ADD),
                 r_ins(6,1,5,A_SLL), i_ins(E_BNE,5,1), r_ins(6,5,1,A_ADD), r_ins(6,5,1,A_ADD),
                 r_ins(6,5,1,A_SLL)};
      lu_br  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      lu_exp = '{V_LU, V_NONE, V_LU, V_NONE, V_NONE, V_LU, V_NONE, V_NONE, V_LU};

      // reset with a mul sitting in DX: outputs must still be low
      reset_n = 1'b0; fd_insn = NOP; dx_insn = r_ins(4,1,2,A_MUL);
      branch_taken = 1'b0; md_ready = 1'b0;
      #2;
      chk("rst_out_a", a_vec, V_NONE);
      chk("rst_out_b", b_vec, V_NONE);
      chk("rst_cnt", a_cnt, 0);
      cyc_edge();
      reset_n = 1'b1; dx_insn = NOP;
      @(negedge clock); chk("idle", a_vec, V_NONE);
      cyc_edge();

      // short mul: ready on the 6th cycle -> 5 stall cycles
      dx_insn = r_ins(4,1,2,A_MUL);
      for (int i = 0; i <= 5; i++) begin
         md_ready = (i == 5);
         @(negedge clock);
         chk($sformatf("mul5_c%0d", i), a_vec, (i == 0) ? V_START : (i == 5) ? V_NONE : V_WAIT);
         cyc_edge();
      end
      md_ready = 1'b0;

      // canonical load-use: one stall cycle, clears once the lw advances
      dx_insn = i_ins(E_LW,5,2); fd_insn = r_ins(6,5,1,A_ADD);
      @(negedge clock); chk("lu_hit", a_vec, V_LU);
      cyc_edge();
      dx_insn = NOP;
      @(negedge clock); chk("lu_clear", a_vec, V_NONE);
      chk("perf_cnt6", a_cnt, PERF ? 6 : 0);
      cyc_edge();

      for (int i = 0; i < 9; i++) begin
         dx_insn = lu_dx[i]; fd_insn = lu_fd[i]; branch_taken = lu_br[i];
         @(negedge clock);
         chk($sformatf("lu_case%0d", i), a_vec, lu_exp[i]);
         cyc_edge();
      end
      dx_insn = NOP; fd_insn = NOP; branch_taken = 1'b0;
      cyc_edge();

      // long mul: ready pulse after 17 full wait cycles -> 18 stall cycles
      n_stall = 0; n_start = 0;
      dx_insn = r_ins(4,1,2,A_MUL);
      for (int i = 0; i <= 18; i++) begin
         md_ready = (i == 18);
         @(negedge clock);
         if (a_pc && a_fd && a_dx && a_xmb) n_stall++;
         if (a_st) n_start++;
         if (i == 18) chk("md_release", a_vec, V_NONE);
         cyc_edge();
      end
      chk("md_stall_cycles", n_stall, 18);
      chk("md_start_cycles", n_start, 1);

      // back-to-back div right after release starts a fresh handshake
      dx_insn = r_ins(7,4,3,A_DIV); md_ready = 1'b0;
      @(negedge clock); chk("b2b_start", a_vec, V_START);
      cyc_edge();
      md_ready = 1'b1;
      @(negedge clock); chk("b2b_release", a_vec, V_NONE);
      cyc_edge();
      dx_insn = NOP;
      @(negedge clock); chk("ready_in_run", a_vec, V_NONE);
      cyc_edge();
      md_ready = 1'b0;

      // timeout instance: md_ready never comes, dx keeps a mul
      reset_n = 1'b0;
      cyc_edge();
      reset_n = 1'b1; dx_insn = r_ins(4,1,2,A_MUL);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (i == 8 || i == 17)               exp_v = V_TOUT;
         else if (i == 0 || i == 9 || i == 18) exp_v = V_START;
         else                                  exp_v = V_WAIT;
         chk($sformatf("to_c%0d", i), b_vec, exp_v);
         cyc_edge();
      end
      chk("perf_sat", b_cnt, PERF ? 15 : 0);

      // default instance is still waiting; async reset in the middle of it
      @(negedge clock); chk("pre_rst_wait", a_vec, V_WAIT);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_a", a_vec, V_NONE);
      chk("rst_async_cnt", a_cnt, 0);
      cyc_edge();
      reset_n = 1'b1; dx_insn = NOP;
      @(negedge clock); chk("post_rst_idle", a_vec, V_NONE);
      cyc_edge();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
